// File: rtl/fci_bus_slave.sv
// FPGA-side FCI link receiver: decodes forwarded Z80 strobes, collects address/data
// through the CPLD byte mux and serves each bus cycle as a valid/ready request.
module fci_bus_slave #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        CLK50,
  input  logic        RST_N,
  input  logic        FRD_N,
  input  logic        FWR_N,
  input  logic        FMRQ_N,
  input  logic        FIORQ_N,
  input  logic [7:0]  FCI_I,
  output logic [7:0]  FCI_O,
  output logic        FCI_OE,
  output logic [1:0]  FCI_S,
  output logic        FDIR,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic        req_we,
  output logic        req_io,
  input  logic        rsp_valid,
  input  logic        rsp_hit,
  input  logic [7:0]  rsp_data,
  output logic        cyc_abort
);

  typedef enum logic [3:0] {
    IDLE, AL, AH, DAT, REQ, RSP, TURN, DRIVE, REL, DRAIN, WEND
  } state_t;

  localparam logic [2:0] LAST = 3'(SETTLE - 1);

  state_t     state;
  logic [3:0] sync1, sync2;
  logic       rd_s, wr_s, mrq_s, iorq_s;
  logic       cyc, cyc_q, rise_q;
  logic [2:0] cnt;

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {FRD_N, FWR_N, FMRQ_N, FIORQ_N};
      sync2 <= sync1;
    end
  end

  assign {rd_s, wr_s, mrq_s, iorq_s} = sync2;
  assign cyc = (!mrq_s || !iorq_s) && (!rd_s || !wr_s);

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cyc_q  <= cyc;
      rise_q <= cyc && !cyc_q;
    end
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      FCI_O     <= '0;
      FCI_OE    <= 1'b0;
      FCI_S     <= '0;
      FDIR      <= 1'b1;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      req_io    <= 1'b0;
      cyc_abort <= 1'b0;
    end else begin
      cyc_abort <= 1'b0;
      case (state)
        IDLE: begin
          FDIR   <= 1'b1;
          FCI_OE <= 1'b0;
          FCI_S  <= '0;
          if (rise_q) begin
            req_we    <= !wr_s;
            req_io    <= !iorq_s;
            req_wdata <= '0;
            cnt       <= '0;
            state     <= AL;
          end
        end
        AL: begin
          if (cnt == LAST) begin
            req_addr[7:0] <= FCI_I;
            cnt           <= '0;
            FCI_S         <= 2'd1;
            state         <= AH;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        AH: begin
          if (cnt == LAST) begin
            req_addr[15:8] <= FCI_I;
            cnt            <= '0;
            if (req_we) begin
              FCI_S <= 2'd2;
              state <= DAT;
            end else begin
              FCI_S     <= '0;
              req_valid <= 1'b1;
              state     <= REQ;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DAT: begin
          if (cnt == LAST) begin
            req_wdata <= FCI_I;
            cnt       <= '0;
            FCI_S     <= '0;
            req_valid <= 1'b1;
            state     <= REQ;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= req_we ? WEND : RSP;
          end
        end
        RSP: begin
          // A response coinciding with the strobe drop is consumed, so DRAIN is skipped.
          if (!cyc) begin
            cyc_abort <= 1'b1;
            state     <= rsp_valid ? IDLE : DRAIN;
          end else if (rsp_valid) begin
            if (rsp_hit) begin
              FCI_O <= rsp_data;
              FDIR  <= 1'b0;
              state <= TURN;
            end else begin
              state <= WEND;
            end
          end
        end
        TURN: begin
          if (!cyc) begin
            cyc_abort <= 1'b1;
            FDIR      <= 1'b1;
            state     <= IDLE;
          end else begin
            FCI_OE <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (rd_s) begin
            FCI_OE <= 1'b0;
            state  <= REL;
          end
        end
        REL: begin
          FDIR  <= 1'b1;
          FCI_O <= '0;
          state <= IDLE;
        end
        DRAIN: begin
          if (rsp_valid) state <= IDLE;
        end
        WEND: begin
          if (!cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fci_bus_slave.md
# fci_bus_slave

FPGA-side receiver for the TSXB FCI link. Watches the forwarded ZX-BUS strobes. It sequences the CPLD's FCI_S byte mux to collect the address and write data of each Z80 cycle, and presents every cycle to the FPGA fabric as a valid/ready request. On a read that the fabric claims, it turns the FCI bus around (FDIR=0) and drives the response byte back to the CPLD, which places it on ZD.

## Interface
- SETTLE, 2: cycles FCI_S is held before sampling FCI_I. Legal range is 1..7.

- CLK50  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- FRD_N, FWR_N, FMRQ_N, FIORQ_N  in  1 each  forwarded Z80 strobes, asynchronous to CLK50
- FCI_I  in  8  FCI pad input
- FCI_O  out  8  FCI pad output data
- FCI_OE  out  1  FCI pad output enable
- FCI_S  out  2  CPLD mux select: 0 = ZA[7:0], 1 = ZA[15:8], 2 = ZD; 3 is unused and never driven
- FDIR  out  1  1 = CPLD drives FCI; 0 = FPGA drives FCI and the CPLD drives ZD
- req_valid  out  1  cycle request to fabric
- req_ready  in  1  fabric accepts request
- req_addr  out  16  Z80 address
- req_wdata  out  8  write data; valid when req_we=1
- req_we  out  1  1 = write, 0 = read
- req_io  out  1  1 = IORQ cycle, 0 = MREQ cycle
- rsp_valid  in  1  read response strobe; exactly one per accepted read
- rsp_hit  in  1  fabric claims the read
- rsp_data  in  8  read data
- cyc_abort  out  1  one-cycle pulse when a read cycle ends before its response is driven

## Operation
- Strobe synchronisation:
  - All four strobes pass through 2-FF synchronisers.
  - cyc = (!mrq_s | !iorq_s) & (!rd_s | !wr_s).
  - Refresh cycles and INTACK cycles (no RD/WR) are ignored.
- States: IDLE, AL, AH, DAT, REQ, RSP, TURN, DRIVE, REL, DRAIN, WEND.
- IDLE: FDIR=1, FCI_OE=0, FCI_S=0. A rising edge of cyc latches we=!wr_s and io=!iorq_s, then goes to AL.
- AL, AH, DAT:
  - On entry FCI_S is set to 0, 1 or 2 respectively.
  - A settle counter runs; FCI_I is captured on the SETTLE-th cycle in the state into addr[7:0], addr[15:8] or wdata.
  - Order is AL -> AH, then DAT if we, then REQ.
- REQ:
  - req_valid=1 with stable req_* until req_ready is seen high.
  - Writes then go to WEND; reads go to RSP.
  - The request is never withdrawn, even if cyc drops while in REQ.
- RSP:
  - On rsp_valid with rsp_hit=1: latch rsp_data and go to TURN.
  - On rsp_valid with rsp_hit=0: go to WEND.
  - If cyc drops before rsp_valid: pulse cyc_abort and go to DRAIN.
- DRAIN: waits for rsp_valid, discards the response, then goes to IDLE.
- TURN: FDIR=0 with FCI_OE=0 for exactly one cycle. This is the bus turnaround; no contention.
- DRIVE:
  - FDIR=0, FCI_OE=1, FCI_O = latched data.
  - Held until rd_s=1.
  - If cyc drops before DRIVE is reached, abort per RSP.
- REL: FCI_OE=0 while FDIR stays 0 for one cycle, then IDLE (FDIR=1).
- WEND: waits for cyc=0, then IDLE. This prevents retriggering within one bus cycle.
- Bus release rules:
  - FDIR=0 is never asserted outside TURN, DRIVE and REL.
  - FCI_OE=1 is never asserted unless FDIR has already been 0 for at least one cycle.
- Reset:
  - Asynchronous.
  - Forces IDLE, FDIR=1, FCI_OE=0, FCI_O=0, FCI_S=0, req_valid=0, req_* = 0, cyc_abort=0.
  - The synchronisers reset to 1 (inactive).
  - Asserting reset mid-DRIVE releases the bus immediately.

## Timing
- Start detection: 2 CLK50 cycles of sync plus 1 edge-detect cycle after the strobe asserts.
- Each capture state lasts SETTLE cycles. FCI_S changes on the state-entry edge; the sample is taken at the end of the last cycle.
- Write: req_valid rises 1 + 3*SETTLE cycles after the edge is detected (7 with default SETTLE).
- Read: req_valid rises 1 + 2*SETTLE cycles after the edge is detected (5 with default SETTLE).
- Read turnaround: with response latency L (rsp_valid L cycles after acceptance), FCI_O is valid on the pads L+2 cycles after acceptance.
- Release: FCI_OE drops 1 cycle after rd_s=1, and FDIR returns to 1 one cycle later.
- req_ready may be tied high; acceptance then happens in the first REQ cycle.
- A response arriving in the same cycle that cyc drops is treated as an abort (DRAIN is skipped because the response is consumed; go to IDLE).

## Test plan
- IO write:
  - Stimulus: OUT (#F8AF),#5A; model CPLD mux returns AF, F8, 5A for FCI_S = 0, 1, 2.
  - Response: one request with req_addr=F8AF, req_wdata=5A, req_we=1, req_io=1; FDIR stays 1 throughout.
- Memory read, claimed:
  - Stimulus: read at 4000 with rsp_hit=1, rsp_data=C3, L=2.
  - Response: FDIR falls one cycle before FCI_OE rises and FCI_O=C3 until FRD_N rises; then FCI_OE falls, then FDIR returns to 1.
- Memory read, unclaimed:
  - Stimulus: rsp_hit=0.
  - Response: FDIR=1 and FCI_OE=0 for the whole cycle; FSM returns to IDLE only after the strobes deassert.
- Aborted read:
  - Stimulus: FRD_N deasserts while in RSP; rsp_valid arrives 3 cycles later.
  - Response: single cyc_abort pulse; FDIR never 0; the late response is discarded; the next cycle is decoded normally.
- Reset during DRIVE:
  - Stimulus: assert RST_N=0 asynchronously.
  - Response: FCI_OE=0 and FDIR=1 without a clock edge; req_valid=0.
- Refresh cycle:
  - Stimulus: MRQ low with RD and WR high.
  - Response: no request issued; FCI_S stays 0.
